// File: rtl/ccff_loader.sv
// Configuration flip-flop chain loader: takes bitstream words over valid/ready,
// serialises exactly CHAIN_LEN bits onto ccff_head, settles, then flags done.
module ccff_loader #(
  parameter  int DATA_W     = 8,
  parameter  int CHAIN_LEN  = 64,
  parameter  int SETTLE_CYC = 4,
  parameter  int MSB_FIRST  = 1,
  localparam int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_err,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full;
  logic [IDX_W-1:0]  idx_q;
  logic [SC_W-1:0]   settle_q;
  logic              head_q;
  logic              cur_bit;
  logic              last_bit;
  logic              word_end;
  logic              start_load;

  // The buffer is kept pre-aligned so the outgoing bit is always at one end.
  assign cur_bit    = (MSB_FIRST != 0) ? buf_q[DATA_W-1] : buf_q[0];
  assign last_bit   = (bit_count == CNT_W'(CHAIN_LEN - 1));
  assign word_end   = (idx_q == IDX_W'(DATA_W - 1));
  assign start_load = start && ((state_q == IDLE) || (state_q == DONE));

  // Decoded from registered state so a reset clears them without waiting for an edge.
  assign bs_ready      = (state_q == LOAD) && !buf_full;
  assign ccff_shift_en = (state_q == LOAD) && buf_full;
  assign ccff_head     = ccff_shift_en ? cur_bit : head_q;
  assign busy          = (state_q == LOAD) || (state_q == SETTLE);
  assign done          = (state_q == DONE);

  // NOTE: state and datapath registers use non-blocking assignments only, so every
  // process samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       if (ccff_shift_en && last_bit) state_d = SETTLE;
      SETTLE:     if (settle_q == SC_W'(SETTLE_CYC - 1)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      buf_q     <= '0;
      buf_full  <= 1'b0;
      idx_q     <= '0;
      head_q    <= 1'b0;
      bit_count <= '0;
      tail_err  <= 1'b0;
    end else if (start_load) begin
      buf_full  <= 1'b0;
      idx_q     <= '0;
      bit_count <= '0;
      tail_err  <= 1'b0;
    end else if (state_q == LOAD) begin
      if (ccff_shift_en) begin
        head_q    <= cur_bit;
        bit_count <= bit_count + CNT_W'(1);
        buf_q     <= (MSB_FIRST != 0) ? (buf_q << 1) : (buf_q >> 1);
        if (ccff_tail) tail_err <= 1'b1;
        // Reaching the chain length discards whatever is left of the word.
        if (last_bit || word_end) begin
          buf_full <= 1'b0;
          idx_q    <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end else if (bs_valid) begin
        buf_q    <= bs_data;
        buf_full <= 1'b1;
        idx_q    <= '0;
      end
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset)                 settle_q <= '0;
    else if (state_q == SETTLE) settle_q <= settle_q + SC_W'(1);
    else                        settle_q <= '0;
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: a behavioural chain model drives ccff_tail,
// expected bit streams and timing are derived from the word list arithmetically.
module tb_ccff_loader;

  localparam int DATA_W     = 8;
  localparam int CHAIN_LEN  = 20;
  localparam int SETTLE_CYC = 4;
  localparam int CNT_W      = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS     = (CHAIN_LEN + DATA_W - 1) / DATA_W;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start;
  logic [DATA_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              tail_err;
  logic [CNT_W-1:0]  bit_count;

  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] preset_pat;
  logic                 preset_go;
  logic [DATA_W-1:0]    words [NWORDS];

  int checks   = 0;
  int failures = 0;

  ccff_loader #(
    .DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN), .SETTLE_CYC(SETTLE_CYC), .MSB_FIRST(1)
  ) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .tail_err(tail_err), .bit_count(bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: reset clears it, shifting moves head toward the tail (MSB).
  assign ccff_tail = chain[CHAIN_LEN-1];
  always @(posedge prog_clk or posedge pReset) begin
    if (pReset)             chain <= '0;
    else if (preset_go)     chain <= preset_pat;
    else if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NWORDS; i++) words[i] = DATA_W'($urandom);
  endtask

  task automatic pulse_reset();
    @(negedge prog_clk);
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  task automatic preset_chain(input logic [CHAIN_LEN-1:0] pat);
    @(negedge prog_clk);
    preset_pat = pat;
    preset_go  = 1'b1;
    @(negedge prog_clk);
    preset_go  = 1'b0;
  endtask

  // One full load. gap: cycles bs_valid is withheld while the loader is ready
  // (between words); mid_start: pulse start during LOAD; abort_after: pReset after
  // that many shifts (0 = never).
  task automatic run_load(input int gap, input bit mid_start, input int abort_after);
    logic [CHAIN_LEN-1:0] exp_stream;
    logic [CHAIN_LEN-1:0] chain_before;
    int  shifts, accepted, gap_left, load_cyc, settle_cyc, mid_at;
    bit  exp_terr, have_head, last_head;

    // Bit i of the stream lands at chain index CHAIN_LEN-1-i after CHAIN_LEN shifts.
    for (int i = 0; i < CHAIN_LEN; i++)
      exp_stream[CHAIN_LEN-1-i] = words[i / DATA_W][DATA_W-1-(i % DATA_W)];
    chain_before = chain;
    mid_at = $urandom_range(2, 15);

    @(negedge prog_clk);
    start    = 1'b1;
    bs_valid = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    check("start_flags", {busy, done, tail_err, bs_ready}, 4'b1001);
    check("start_cnt", bit_count, 0);

    shifts = 0; accepted = 0; gap_left = 0; load_cyc = 0; settle_cyc = 0;
    exp_terr = 1'b0; have_head = 1'b0; last_head = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge prog_clk);
      if (done) break;
      if (abort_after > 0 && shifts == abort_after) begin
        pReset = 1'b1;
        #1;
        check("async_reset",
              {bs_ready, ccff_head, ccff_shift_en, busy, done, tail_err, bit_count}, 0);
        @(negedge prog_clk);
        pReset   = 1'b0;
        bs_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      check("tail_err", tail_err, exp_terr);
      check("ready_vs_shift", bs_ready & ccff_shift_en, 0);
      if (ccff_shift_en) begin
        check("shift_busy", busy, 1);
        check("shift_cnt", bit_count, shifts);
        if (shifts < CHAIN_LEN) check("head", ccff_head, exp_stream[CHAIN_LEN-1-shifts]);
        else                    check("overshift", shifts, CHAIN_LEN - 1);
        if (ccff_tail) exp_terr = 1'b1;
        last_head = ccff_head;
        have_head = 1'b1;
        shifts++;
        load_cyc = cyc + 1;
      end else if (busy && shifts == CHAIN_LEN) begin
        settle_cyc++;
        check("settle_cnt", bit_count, CHAIN_LEN);
      end else if (busy && have_head) begin
        check("head_hold", ccff_head, last_head);
      end
      if (bs_ready && gap_left > 0) begin
        bs_valid = 1'b0;
        gap_left--;
      end else begin
        bs_valid = 1'b1;
        bs_data  = (accepted < NWORDS) ? words[accepted] : DATA_W'($urandom);
      end
      if (bs_valid && bs_ready) begin
        accepted++;
        gap_left = gap;
      end
      start = mid_start && (cyc == mid_at);
    end
    start = 1'b0;

    check("reached_done", done, 1);
    check("shift_total", shifts, CHAIN_LEN);
    check("words_taken", accepted, NWORDS);
    check("load_cycles", load_cyc, NWORDS + (NWORDS - 1) * gap + CHAIN_LEN);
    check("settle_len", settle_cyc, SETTLE_CYC);
    check("chain", chain, exp_stream);
    check("tail_err_final", tail_err, |chain_before);
    repeat (3) begin
      bs_valid = 1'($urandom);
      bs_data  = DATA_W'($urandom);
      @(negedge prog_clk);
      check("done_flags", {done, busy, bs_ready, ccff_shift_en}, 4'b1000);
      check("done_cnt", bit_count, CHAIN_LEN);
    end
    check("done_chain", chain, exp_stream);
    bs_valid = 1'b0;
  endtask

  initial begin
    pReset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
    preset_go = 1'b0; preset_pat = '0;
    repeat (2) @(negedge prog_clk);
    check("reset_outputs",
          {bs_ready, ccff_head, ccff_shift_en, busy, done, tail_err, bit_count}, 0);
    pReset = 1'b0;

    // Known vector: first 16 chain bits must read back A5 then 3C.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = DATA_W'($urandom);
    run_load(0, 1'b0, 0);
    check("vector_a53c", chain[CHAIN_LEN-1 -: 16], 16'hA53C);

    // Restart from DONE with stale chain content, start pulsed during LOAD.
    fill_random();
    run_load(0, 1'b1, 0);

    // Valid gaps between words.
    fill_random();
    run_load(5, 1'b0, 0);

    // Abort after 5 shifts, then a full load from IDLE.
    fill_random();
    run_load(0, 1'b0, 5);
    check("idle_after_abort", {busy, done, bit_count}, 0);
    fill_random();
    run_load(0, 1'b0, 0);

    // Un-reset chain: a single stray 1 must raise tail_err without aborting.
    pulse_reset();
    preset_chain(CHAIN_LEN'(1) << $urandom_range(0, CHAIN_LEN - 1));
    fill_random();
    run_load(0, 1'b0, 0);

    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_load($urandom_range(0, 3), 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
